seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Reader for the multiplexed 7-segment bus driven by clock_top (o_Segments/o_Digits). It watches the scan, waits for each digit-enable pattern to settle, decodes the segment pattern back to a BCD nibble, and assembles a full 4-digit frame. It sits in self-test and bench infrastructure as a display monitor, and is also used on-chip for display readback. It publishes digits, dots, a frame strobe, a pattern-error flag and a blank-detect flag.

Parameters:
SETTLE_CYCLES, 4, consecutive stable cycles required before a digit is captured (minimum 1)
BLANK_CYCLES, 256, consecutive cycles with no digit enabled before the display is declared blank

Ports:
i_Clock  input  1  system clock, all logic on rising edge
i_Reset_n  input  1  reset, asynchronous assert, active-low
i_Segments  input  8  {dp,g,f,e,d,c,b,a}, active-high
i_Digits  input  4  digit enables, active-high, bit3 = leftmost digit
o_Code  output  16  {digit3,digit2,digit1,digit0} BCD nibbles; 4'hF = undecodable
o_Dots  output  4  dp bit captured per digit
o_Frame_Valid  output  1  one-cycle strobe; o_Code/o_Dots updated in the same cycle
o_Pattern_Error  output  1  last published frame contained an undecodable digit
o_Blank  output  1  no digit enabled for at least BLANK_CYCLES cycles

Behaviour:
- Reset (async, i_Reset_n=0): o_Code=16'hFFFF, o_Dots=0, o_Frame_Valid=0, o_Pattern_Error=0, o_Blank=0. The FSM enters S_IDLE, and the seen-mask, shadow registers and counters clear. Reset asserted mid-operation discards any partial frame immediately.
- Input stage: i_Segments and i_Digits are registered once (r_Seg, r_Dig). All decisions use the registered values.
- Decode (combinational on the snapshot, ignoring dp): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9. Any other value maps to 4'hF and marks the capture invalid.
- FSM:
  - S_IDLE: if r_Dig==0, stay. If r_Dig!=0, load the snapshot {r_Seg,r_Dig}, clear the settle counter and go to S_SETTLE.
  - S_SETTLE: if {r_Seg,r_Dig} differs from the snapshot, reload the snapshot, clear the counter and stay. If r_Dig==0, go to S_IDLE. Otherwise increment the counter; when counter==SETTLE_CYCLES-1, go to S_CAPTURE.
  - S_CAPTURE (exactly 1 cycle): for every bit i set in the snapshot's digit mask, write the decoded nibble into shadow digit i and dp into shadow dot i. OR the mask into the seen-mask and OR the invalid flag into the shadow error. Go to S_HOLD.
  - S_HOLD: stay while r_Dig equals the snapshot mask; segment changes are ignored. If r_Dig==0, go to S_IDLE. If r_Dig changes to another nonzero value, reload the snapshot and go to S_SETTLE.
- Multi-hot masks are legal, e.g. 4'b1111 writes all four digits in one capture.
- Frame publish: at the S_CAPTURE edge, if (seen-mask | snapshot mask)==4'b1111:
  - copy shadow into o_Code/o_Dots and the shadow error into o_Pattern_Error;
  - assert o_Frame_Valid for exactly one cycle;
  - clear the seen-mask and shadow error.
  - Outside this edge, o_Code/o_Dots/o_Pattern_Error never change.
- Recapturing an already-seen digit before the frame completes overwrites its shadow value; no error.
- Latency: with inputs stable from before edge 1, starting from S_IDLE, o_Frame_Valid is high in the cycle after edge SETTLE_CYCLES+3.
- Blank detect:
  - A saturating counter increments every cycle r_Dig==0 and clears when r_Dig!=0.
  - On reaching BLANK_CYCLES: o_Blank=1, and the seen-mask and shadow error clear (partial frame discarded); o_Code is retained.
  - o_Blank clears on the first cycle r_Dig!=0.
- Simultaneous events: a frame completion and a blank-timeout cannot coincide because capture requires r_Dig!=0. Reset wins over everything.

Test Plan:
- Reset: hold i_Reset_n=0 with random inputs → o_Code=FFFF, o_Dots=0, all flags 0. Release and hold inputs at 0 → no o_Frame_Valid.
- Static all-on: i_Digits=1111, i_Segments=8'hBF → single o_Frame_Valid after edge SETTLE_CYCLES+3; o_Code=16'h0000, o_Dots=4'b1111, o_Pattern_Error=0.
- Scan: one-hot 1000/0100/0010/0001, each held 10 cycles with patterns 06/5B/4F/66 → no strobe until the last digit, then exactly one strobe with o_Code=16'h1234, o_Dots=0.
- Glitch rejection: enable 0001 held SETTLE_CYCLES-2 cycles then changed to 0010 → digit0 not captured; a full scan without digit0 produces no strobe.
- Bad pattern: full scan with digit0 pattern 8'h00 → o_Code[3:0]=F, o_Pattern_Error=1. Next clean frame → o_Pattern_Error=0.
- Blank and mid-reset: scan 2 digits, then i_Digits=0 for BLANK_CYCLES → o_Blank=1 and the later 2-digit scan yields no strobe. Separately, assert reset during S_SETTLE → outputs return to reset values without waiting for a clock.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Readback monitor for a multiplexed 7-segment scan bus: settles on each
// digit-enable pattern, decodes segments to BCD and publishes whole 4-digit frames.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BLANK_CYCLES  = 256
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [7:0]  i_Segments,
  input  logic [3:0]  i_Digits,
  output logic [15:0] o_Code,
  output logic [3:0]  o_Dots,
  output logic        o_Frame_Valid,
  output logic        o_Pattern_Error,
  output logic        o_Blank
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int BCW = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      r_seg_q;
  logic [3:0]      r_dig_q;
  logic [7:0]      snap_seg_q, snap_seg_d;
  logic [3:0]      snap_dig_q, snap_dig_d;
  logic [SCW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [BCW-1:0]  blank_cnt_q, blank_cnt_d;
  logic            blank_q, blank_d;
  logic [15:0]     shadow_code_q, shadow_code_d;
  logic [3:0]      shadow_dots_q, shadow_dots_d;
  logic [3:0]      seen_q, seen_d;
  logic            shadow_err_q, shadow_err_d;
  logic [15:0]     code_q, code_d;
  logic [3:0]      dots_q, dots_d;
  logic            perr_q, perr_d;
  logic            fv_q, fv_d;
  logic            capture;
  logic            blank_hit;
  logic [3:0]      cap_nib;
  logic            cap_bad;

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = 4'd0;
      7'h06:   seg_decode = 4'd1;
      7'h5B:   seg_decode = 4'd2;
      7'h4F:   seg_decode = 4'd3;
      7'h66:   seg_decode = 4'd4;
      7'h6D:   seg_decode = 4'd5;
      7'h7D:   seg_decode = 4'd6;
      7'h07:   seg_decode = 4'd7;
      7'h7F:   seg_decode = 4'd8;
      7'h6F:   seg_decode = 4'd9;
      default: seg_decode = 4'hF;
    endcase
  endfunction

  assign cap_nib = seg_decode(snap_seg_q[6:0]);
  assign cap_bad = (cap_nib == 4'hF);

  always_comb begin
    state_d      = state_q;
    snap_seg_d   = snap_seg_q;
    snap_dig_d   = snap_dig_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (r_dig_q != 4'd0) begin
          snap_seg_d   = r_seg_q;
          snap_dig_d   = r_dig_q;
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_dig_q == 4'd0) begin
          state_d = S_IDLE;
        end else if ({r_seg_q, r_dig_q} != {snap_seg_q, snap_dig_q}) begin
          snap_seg_d   = r_seg_q;
          snap_dig_d   = r_dig_q;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SCW'(1);
          if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Segment changes while the same digit stays enabled are ignored.
        if (r_dig_q == 4'd0) begin
          state_d = S_IDLE;
        end else if (r_dig_q != snap_dig_q) begin
          snap_seg_d   = r_seg_q;
          snap_dig_d   = r_dig_q;
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign blank_hit = (r_dig_q == 4'd0) && (blank_cnt_q == BCW'(BLANK_CYCLES - 1));

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    blank_d     = blank_q;
    if (r_dig_q != 4'd0) begin
      blank_cnt_d = '0;
      blank_d     = 1'b0;
    end else begin
      if (blank_cnt_q != BCW'(BLANK_CYCLES)) blank_cnt_d = blank_cnt_q + BCW'(1);
      if (blank_hit) blank_d = 1'b1;
    end
  end

  always_comb begin
    shadow_code_d = shadow_code_q;
    shadow_dots_d = shadow_dots_q;
    seen_d        = seen_q;
    shadow_err_d  = shadow_err_q;
    code_d        = code_q;
    dots_d        = dots_q;
    perr_d        = perr_q;
    fv_d          = 1'b0;
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (snap_dig_q[i]) begin
          shadow_code_d[4*i +: 4] = cap_nib;
          shadow_dots_d[i]        = snap_seg_q[7];
        end
      end
      seen_d       = seen_q | snap_dig_q;
      shadow_err_d = shadow_err_q | cap_bad;
      // Publish includes the digits written by this very capture.
      if (seen_d == 4'hF) begin
        code_d       = shadow_code_d;
        dots_d       = shadow_dots_d;
        perr_d       = shadow_err_d;
        fv_d         = 1'b1;
        seen_d       = 4'd0;
        shadow_err_d = 1'b0;
      end
    end
    if (blank_hit) begin
      seen_d       = 4'd0;
      shadow_err_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q       <= S_IDLE;
      r_seg_q       <= 8'd0;
      r_dig_q       <= 4'd0;
      snap_seg_q    <= 8'd0;
      snap_dig_q    <= 4'd0;
      settle_cnt_q  <= '0;
      blank_cnt_q   <= '0;
      blank_q       <= 1'b0;
      shadow_code_q <= 16'hFFFF;
      shadow_dots_q <= 4'd0;
      seen_q        <= 4'd0;
      shadow_err_q  <= 1'b0;
      code_q        <= 16'hFFFF;
      dots_q        <= 4'd0;
      perr_q        <= 1'b0;
      fv_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_seg_q       <= i_Segments;
      r_dig_q       <= i_Digits;
      snap_seg_q    <= snap_seg_d;
      snap_dig_q    <= snap_dig_d;
      settle_cnt_q  <= settle_cnt_d;
      blank_cnt_q   <= blank_cnt_d;
      blank_q       <= blank_d;
      shadow_code_q <= shadow_code_d;
      shadow_dots_q <= shadow_dots_d;
      seen_q        <= seen_d;
      shadow_err_q  <= shadow_err_d;
      code_q        <= code_d;
      dots_q        <= dots_d;
      perr_q        <= perr_d;
      fv_q          <= fv_d;
    end
  end

  assign o_Code          = code_q;
  assign o_Dots          = dots_q;
  assign o_Frame_Valid   = fv_q;
  assign o_Pattern_Error = perr_q;
  assign o_Blank         = blank_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: reset, static, scan, glitch, bad pattern,
// blank timeout and asynchronous mid-frame reset.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int BLANK  = 256;

  logic        clk;
  logic        rst_n;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic [15:0] code;
  logic [3:0]  dots;
  logic        fv;
  logic        perr;
  logic        blank;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .BLANK_CYCLES(BLANK)) dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Segments     (seg),
    .i_Digits       (dig),
    .o_Code         (code),
    .o_Dots         (dots),
    .o_Frame_Valid  (fv),
    .o_Pattern_Error(perr),
    .o_Blank        (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (fv) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input logic [3:0] d, input logic [7:0] s);
    dig = d;
    seg = s;
    tick(10);
  endtask

  initial begin
    int s0;
    int first;
    rst_n = 1'b0;
    dig   = 4'($urandom);
    seg   = 8'($urandom);
    tick(3);
    chk("rst_code", code, 16'hFFFF);
    chk("rst_dots", dots, 4'h0);
    chk("rst_fv", fv, 1'b0);
    chk("rst_perr", perr, 1'b0);
    chk("rst_blank", blank, 1'b0);
    dig = 4'h0;
    seg = 8'h00;
    rst_n = 1'b1;
    s0 = strobes;
    tick(20);
    chk("idle_no_strobe", strobes - s0, 0);

    // static all-on: strobe expected after edge SETTLE+3
    s0 = strobes;
    first = 0;
    dig = 4'b1111;
    seg = 8'hBF;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      if (fv && first == 0) first = n;
    end
    chk("static_latency", first, SETTLE + 3);
    chk("static_strobes", strobes - s0, 1);
    chk("static_code", code, 16'h0000);
    chk("static_dots", dots, 4'hF);
    chk("static_perr", perr, 1'b0);
    scan(4'h0, 8'h00);

    // one-hot scan
    s0 = strobes;
    scan(4'b1000, 8'h06);
    scan(4'b0100, 8'h5B);
    scan(4'b0010, 8'h4F);
    chk("scan_early", strobes - s0, 0);
    scan(4'b0001, 8'h66);
    chk("scan_strobes", strobes - s0, 1);
    chk("scan_code", code, 16'h1234);
    chk("scan_dots", dots, 4'h0);
    scan(4'h0, 8'h00);

    // glitch: digit0 enabled too briefly to capture
    s0 = strobes;
    dig = 4'b0001;
    seg = 8'h7F;
    tick(SETTLE - 2);
    scan(4'b0010, 8'h3F);
    scan(4'b1000, 8'h3F);
    scan(4'b0100, 8'h3F);
    chk("glitch_no_strobe", strobes - s0, 0);
    tick(5);

    // bad pattern on digit0
    s0 = strobes;
    scan(4'b1000, 8'h7F);
    scan(4'b0100, 8'h6F);
    scan(4'b0010, 8'h3F);
    scan(4'b0001, 8'h00);
    chk("bad_strobes", strobes - s0, 1);
    chk("bad_code", code, 16'h890F);
    chk("bad_perr", perr, 1'b1);
    scan(4'h0, 8'h00);

    // clean frame clears the error, dp on digit2
    s0 = strobes;
    scan(4'b1000, 8'h6D);
    scan(4'b0100, 8'hFD);
    scan(4'b0010, 8'h07);
    scan(4'b0001, 8'h5B);
    chk("clean_strobes", strobes - s0, 1);
    chk("clean_code", code, 16'h5672);
    chk("clean_dots", dots, 4'b0100);
    chk("clean_perr", perr, 1'b0);

    // blank timeout discards a partial frame
    scan(4'b1000, 8'h06);
    scan(4'b0100, 8'h06);
    dig = 4'h0;
    seg = 8'h00;
    tick(BLANK);
    chk("blank_early", blank, 1'b0);
    tick(1);
    chk("blank_set", blank, 1'b1);
    chk("blank_code_kept", code, 16'h5672);
    s0 = strobes;
    scan(4'b0010, 8'h06);
    chk("blank_clear", blank, 1'b0);
    scan(4'b0001, 8'h06);
    chk("blank_no_strobe", strobes - s0, 0);
    scan(4'h0, 8'h00);

    // asynchronous reset while settling on the last digit
    scan(4'b1000, 8'h3F);
    scan(4'b0100, 8'h3F);
    scan(4'b0010, 8'h3F);
    dig = 4'b0001;
    seg = 8'h06;
    tick(3);
    rst_n = 1'b0;
    #2;
    chk("mrst_code", code, 16'hFFFF);
    chk("mrst_dots", dots, 4'h0);
    chk("mrst_fv", fv, 1'b0);
    chk("mrst_perr", perr, 1'b0);
    chk("mrst_blank", blank, 1'b0);
    dig = 4'h0;
    seg = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    s0 = strobes;
    scan(4'b0001, 8'h06);
    chk("mrst_no_strobe", strobes - s0, 0);
    chk("mrst_code_hold", code, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
